uart_hex_word_ctrl: RTL and testbench
=====================================

Name: uart_hex_word_ctrl

Overview:
Sequencer between the UART, the ASCII/hex translator and the MIPS I/O registers. The Rx side collects NIBBLES ASCII hex characters from the UART, converts each one through the translator's Rx path and packs them MSB-first into a word for the CPU. The Tx side takes a CPU word, splits it into nibbles MSB-first, converts each through the translator's Tx path and hands the characters to the UART one at a time, using the UART's start/busy handshake.

Parameters:
Nbits, 8, character and translator data width
NIBBLES, 8, hex characters per word; word width = 4*NIBBLES

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
uart_rx_data  input  Nbits  received character
uart_rx_valid  input  1  one-cycle strobe, uart_rx_data valid
tr_rx_ascii  output  Nbits  to translator Data_in_Rx; equals uart_rx_data, case-folded when UPPERCASE_HEX_EN is defined
tr_rx_value  input  Nbits  from translator Data_out_Rx; only bits [3:0] used
rx_word  output  4*NIBBLES  assembled word
rx_word_valid  output  1  level; held until rx_word_ack
rx_word_ack  input  1  CPU consumed rx_word
rx_err  output  1  one-cycle pulse: non-hex character discarded
rx_overrun  output  1  one-cycle pulse: character dropped while word held
tx_word  input  4*NIBBLES  word to send
tx_req  input  1  start send; sampled only in TX_IDLE
tx_busy  output  1  high whenever Tx FSM is not TX_IDLE
tx_done  output  1  one-cycle pulse after last character is accepted
tr_tx_value  output  Nbits  to translator Data_in_Tx; {0, current nibble}
tr_tx_ascii  input  Nbits  from translator Data_out_Tx
uart_tx_data  output  Nbits  character to UART
uart_tx_start  output  1  one-cycle start strobe
uart_tx_busy  input  1  UART busy; contract: rises the cycle after uart_tx_start

Behaviour:
- Reset (async, reset=0): every output register is 0. This covers rx_word, rx_word_valid, rx_err, rx_overrun, tx_done, uart_tx_start and uart_tx_data. Both FSMs go to idle, counters go to 0, shift registers clear.
- The translator is combinational. tr_* signals are combinational and are sampled in the same cycle.
- Hex validity is decided in this block, because the translator maps invalid input to 0. Valid characters are 48..57 and 97..102.
- Rx FSM has two states, RX_COLLECT and RX_HOLD.
  - RX_COLLECT, valid char strobe: acc <= {acc[4*NIBBLES-5:0], tr_rx_value[3:0]}, cnt++.
  - RX_COLLECT, invalid char: acc and cnt unchanged; rx_err pulses in the next cycle.
  - When the strobe brings cnt to NIBBLES: rx_word <= new acc, rx_word_valid=1 in the next cycle, cnt <= 0, go to RX_HOLD.
  - RX_HOLD: any uart_rx_valid is dropped and pulses rx_overrun. When rx_word_ack=1, clear rx_word_valid the next cycle and return to RX_COLLECT. An ack and a strobe in the same cycle: the character is dropped.
  - rx_word_ack outside RX_HOLD is ignored.
- Tx FSM has four states: TX_IDLE, TX_SEND, TX_WAIT, TX_DONE.
  - TX_IDLE: on tx_req, sh <= tx_word, idx <= 0, go to TX_SEND.
  - TX_SEND: tr_tx_value = sh[MSB nibble]. When uart_tx_busy=0, register uart_tx_data <= tr_tx_ascii, pulse uart_tx_start for one cycle and go to TX_WAIT. While uart_tx_busy=1, stay.
  - TX_WAIT: skip the first cycle, because busy has not risen yet. After that, when uart_tx_busy=0: if idx==NIBBLES-1 go to TX_DONE; else sh <<= 4, idx++, go to TX_SEND.
  - TX_DONE: tx_done=1 for one cycle, then go to TX_IDLE.
  - tx_req outside TX_IDLE is ignored.
  - Minimum character spacing is 3 cycles plus the UART frame time.
- The Rx and Tx FSMs are fully independent and may run simultaneously.
- Reset mid-operation: a partial word is discarded, and any in-flight Tx is aborted without tx_done.

Optional Feature:
UPPERCASE_HEX_EN.
- Defined: 'A'..'F' (65..70) are valid. tr_rx_ascii = uart_rx_data+32 for these, so the translator sees lowercase.
- Undefined: 65..70 are invalid and pulse rx_err. tr_rx_ascii = uart_rx_data.
- Tx output is uppercase in both cases, as produced by the translator.

Decomposition:
- Shared package (hex_ctrl_pkg) holds:
  - rx_state_t and tx_state_t enums.
  - ASCII constants: ASCII_0=48, ASCII_9=57, ASCII_LA=97, ASCII_LF=102, ASCII_UA=65, ASCII_UF=70, CASE_OFFSET=32.
- One natural sub-module: hex_tx_seq, containing the Tx FSM, the shift register and the UART handshake. The Rx path stays in the top.

Test Plan:
- Rx "1a2b3c4d" (49,97,50,98,51,99,52,100) -> rx_word_valid=1 one cycle after the 8th strobe, rx_word=32'h1A2B3C4D; ack -> valid=0 next cycle.
- Rx "12g45678" ('g'=103) -> one rx_err pulse, and still no rx_word_valid after the 8th strobe. Send '9' (57) -> rx_word=32'h12456789.
- Hold word, send '0' without ack -> rx_overrun pulse, word unchanged. Ack, then send 8 chars -> new word correct.
- tx_word=32'hDEADBEEF, tx_req, UART model busy 10 cycles per char -> uart_tx_data sequence 68,69,65,68,66,69,69,70, then one tx_done pulse. tx_req during send is ignored.
- Assert reset=0 after the 3rd Tx character and the 5th Rx character -> all outputs 0, no tx_done. After release, a full Rx word "ffffffff" -> 32'hFFFFFFFF.
- Rx "ABCDEF01": with UPPERCASE_HEX_EN -> 32'hABCDEF01; without -> 6 rx_err pulses, no word.

Source files
------------

// File: rtl/hex_ctrl_pkg.sv
// Shared types and ASCII constants for the UART hex word controller.
package hex_ctrl_pkg;

  typedef enum logic {
    RX_COLLECT = 1'b0,
    RX_HOLD    = 1'b1
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_WAIT = 2'd2,
    TX_DONE = 2'd3
  } tx_state_t;

  localparam int ASCII_0     = 48;
  localparam int ASCII_9     = 57;
  localparam int ASCII_LA    = 97;
  localparam int ASCII_LF    = 102;
  localparam int ASCII_UA    = 65;
  localparam int ASCII_UF    = 70;
  localparam int CASE_OFFSET = 32;

  function automatic logic in_range(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/hex_tx_seq.sv
// Tx sequencer: splits a word into nibbles MSB-first and feeds the translated
// characters to the UART using its start/busy handshake.
module hex_tx_seq
  import hex_ctrl_pkg::*;
#(
  parameter int Nbits   = 8,
  parameter int NIBBLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4*NIBBLES-1:0] tx_word,
  input  logic                 tx_req,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [Nbits-1:0]     tr_tx_value,
  input  logic [Nbits-1:0]     tr_tx_ascii,
  output logic [Nbits-1:0]     uart_tx_data,
  output logic                 uart_tx_start,
  input  logic                 uart_tx_busy,
  output tx_state_t            state_dbg
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  tx_state_t         state_q, state_d;
  logic [W-1:0]      sh_q, sh_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              wait_first_q, wait_first_d;
  logic [Nbits-1:0]  data_q, data_d;
  logic              start_q, start_d;
  logic              done_q, done_d;

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    idx_d        = idx_q;
    wait_first_d = wait_first_q;
    data_d       = data_q;
    start_d      = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (tx_req) begin
          sh_d    = tx_word;
          idx_d   = '0;
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!uart_tx_busy) begin
          data_d       = tr_tx_ascii;
          start_d      = 1'b1;
          wait_first_d = 1'b1;
          state_d      = TX_WAIT;
        end
      end
      TX_WAIT: begin
        // UART busy only rises the cycle after start, so ignore it for one cycle.
        if (wait_first_q) begin
          wait_first_d = 1'b0;
        end else if (!uart_tx_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = TX_DONE;
          end else begin
            sh_d    = {sh_q[W-5:0], 4'h0};
            idx_d   = idx_q + 1'b1;
            state_d = TX_SEND;
          end
        end
      end
      TX_DONE: state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
    done_d = (state_d == TX_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= TX_IDLE;
      sh_q         <= '0;
      idx_q        <= '0;
      wait_first_q <= 1'b0;
      data_q       <= '0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      idx_q        <= idx_d;
      wait_first_q <= wait_first_d;
      data_q       <= data_d;
      start_q      <= start_d;
      done_q       <= done_d;
    end
  end

  assign tr_tx_value   = {{(Nbits-4){1'b0}}, sh_q[W-1 -: 4]};
  assign uart_tx_data  = data_q;
  assign uart_tx_start = start_q;
  assign tx_done       = done_q;
  assign tx_busy       = (state_q != TX_IDLE);
  assign state_dbg     = state_q;

endmodule

// File: rtl/uart_hex_word_ctrl.sv
// UART <-> hex translator <-> CPU word sequencer; Rx assembly lives here, Tx in hex_tx_seq.
// Optional macro UPPERCASE_HEX_EN accepts 'A'..'F' on Rx by folding them to lowercase.
// Handshakes: rx_word_valid is a level held until a cycle with rx_word_ack=1 (ack is
// ignored otherwise); tx_req is accepted only while tx_busy=0; uart_tx_start is issued
// only while uart_tx_busy=0 and the UART must raise busy the following cycle.
module uart_hex_word_ctrl
  import hex_ctrl_pkg::*;
#(
  parameter int Nbits   = 8,
  parameter int NIBBLES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [Nbits-1:0]     uart_rx_data,
  input  logic                 uart_rx_valid,
  output logic [Nbits-1:0]     tr_rx_ascii,
  input  logic [Nbits-1:0]     tr_rx_value,
  output logic [4*NIBBLES-1:0] rx_word,
  output logic                 rx_word_valid,
  input  logic                 rx_word_ack,
  output logic                 rx_err,
  output logic                 rx_overrun,
  input  logic [4*NIBBLES-1:0] tx_word,
  input  logic                 tx_req,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [Nbits-1:0]     tr_tx_value,
  input  logic [Nbits-1:0]     tr_tx_ascii,
  output logic [Nbits-1:0]     uart_tx_data,
  output logic                 uart_tx_start,
  input  logic                 uart_tx_busy,
  output logic                 rx_dbg_state,
  output logic [1:0]           tx_dbg_state
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d, acc_shift;
  logic [W-1:0]  rx_word_q, rx_word_d;
  logic          rx_word_valid_q, rx_word_valid_d;
  logic          rx_err_q, rx_err_d;
  logic          rx_overrun_q, rx_overrun_d;
  logic          is_hex;
  logic          unused_rx_hi;
  tx_state_t     tx_state;

  // The translator returns 0 for junk, so validity has to be judged here.
  always_comb begin
`ifdef UPPERCASE_HEX_EN
    logic is_upper;
    is_upper    = in_range(32'(uart_rx_data), ASCII_UA, ASCII_UF);
    tr_rx_ascii = is_upper ? uart_rx_data + Nbits'(CASE_OFFSET) : uart_rx_data;
    is_hex      = is_upper
                || in_range(32'(uart_rx_data), ASCII_0, ASCII_9)
                || in_range(32'(uart_rx_data), ASCII_LA, ASCII_LF);
`else
    tr_rx_ascii = uart_rx_data;
    is_hex      = in_range(32'(uart_rx_data), ASCII_0, ASCII_9)
                || in_range(32'(uart_rx_data), ASCII_LA, ASCII_LF);
`endif
  end

  assign unused_rx_hi = ^tr_rx_value[Nbits-1:4];
  assign acc_shift    = {acc_q[W-5:0], tr_rx_value[3:0]};

  always_comb begin
    rx_state_d      = rx_state_q;
    cnt_d           = cnt_q;
    acc_d           = acc_q;
    rx_word_d       = rx_word_q;
    rx_word_valid_d = rx_word_valid_q;
    rx_err_d        = 1'b0;
    rx_overrun_d    = 1'b0;
    case (rx_state_q)
      RX_COLLECT: begin
        if (uart_rx_valid) begin
          if (!is_hex) begin
            rx_err_d = 1'b1;
          end else if (cnt_q == LAST_CNT) begin
            rx_word_d       = acc_shift;
            rx_word_valid_d = 1'b1;
            cnt_d           = '0;
            acc_d           = '0;
            rx_state_d      = RX_HOLD;
          end else begin
            acc_d = acc_shift;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RX_HOLD: begin
        // Anything arriving while a word is held is dropped, even alongside the ack.
        rx_overrun_d = uart_rx_valid;
        if (rx_word_ack) begin
          rx_word_valid_d = 1'b0;
          rx_state_d      = RX_COLLECT;
        end
      end
      default: rx_state_d = RX_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q      <= RX_COLLECT;
      cnt_q           <= '0;
      acc_q           <= '0;
      rx_word_q       <= '0;
      rx_word_valid_q <= 1'b0;
      rx_err_q        <= 1'b0;
      rx_overrun_q    <= 1'b0;
    end else begin
      rx_state_q      <= rx_state_d;
      cnt_q           <= cnt_d;
      acc_q           <= acc_d;
      rx_word_q       <= rx_word_d;
      rx_word_valid_q <= rx_word_valid_d;
      rx_err_q        <= rx_err_d;
      rx_overrun_q    <= rx_overrun_d;
    end
  end

  assign rx_word       = rx_word_q;
  assign rx_word_valid = rx_word_valid_q;
  assign rx_err        = rx_err_q;
  assign rx_overrun    = rx_overrun_q;
  assign rx_dbg_state  = rx_state_q;
  assign tx_dbg_state  = tx_state;

  hex_tx_seq #(
    .Nbits   (Nbits),
    .NIBBLES (NIBBLES)
  ) u_tx_seq (
    .clk           (clk),
    .reset         (reset),
    .tx_word       (tx_word),
    .tx_req        (tx_req),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .tr_tx_value   (tr_tx_value),
    .tr_tx_ascii   (tr_tx_ascii),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_start (uart_tx_start),
    .uart_tx_busy  (uart_tx_busy),
    .state_dbg     (tx_state)
  );

endmodule

// File: tb/tb_uart_hex_word_ctrl.sv
// Bench for uart_hex_word_ctrl: translator and UART models, an Rx word model and a Tx
// character scoreboard, with directed cases followed by concurrent random traffic.
module tb_uart_hex_word_ctrl;

  localparam int NIB = 8;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic [7:0]  tr_rx_ascii;
  logic [7:0]  tr_rx_value;
  logic [31:0] rx_word;
  logic        rx_word_valid;
  logic        rx_word_ack;
  logic        rx_err;
  logic        rx_overrun;
  logic [31:0] tx_word;
  logic        tx_req;
  logic        tx_busy;
  logic        tx_done;
  logic [7:0]  tr_tx_value;
  logic [7:0]  tr_tx_ascii;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_start;
  logic        uart_tx_busy;
  logic        rx_dbg_state;
  logic [1:0]  tx_dbg_state;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  uart_hex_word_ctrl #(.Nbits(8), .NIBBLES(NIB)) dut (
    .clk(clk), .reset(reset),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .tr_rx_ascii(tr_rx_ascii), .tr_rx_value(tr_rx_value),
    .rx_word(rx_word), .rx_word_valid(rx_word_valid), .rx_word_ack(rx_word_ack),
    .rx_err(rx_err), .rx_overrun(rx_overrun),
    .tx_word(tx_word), .tx_req(tx_req), .tx_busy(tx_busy), .tx_done(tx_done),
    .tr_tx_value(tr_tx_value), .tr_tx_ascii(tr_tx_ascii),
    .uart_tx_data(uart_tx_data), .uart_tx_start(uart_tx_start),
    .uart_tx_busy(uart_tx_busy),
    .rx_dbg_state(rx_dbg_state), .tx_dbg_state(tx_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // combinational translator: lowercase/digit in, uppercase out
  function automatic logic [7:0] xlat_rx(input logic [7:0] a);
    int c;
    c = int'(a);
    if (c >= 48 && c <= 57)  return 8'(c - 48);
    if (c >= 97 && c <= 102) return 8'(c - 87);
    return 8'd0;
  endfunction

  function automatic logic [7:0] hex_char(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  assign tr_rx_value = xlat_rx(tr_rx_ascii);
  assign tr_tx_ascii = hex_char(int'(tr_tx_value[3:0]));

  // UART Tx model: busy rises the cycle after start, lasts busy_len cycles
  int          busy_cnt = 0;
  bit          busy_rand = 1'b0;
  logic [7:0]  obs_q[$];
  logic [31:0] exp_q[$];
  int          done_cnt = 0;
  int          err_cnt  = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_cnt <= 0;
    end else if (uart_tx_start) begin
      check("start_while_busy", {31'd0, uart_tx_busy}, 32'd0);
      obs_q.push_back(uart_tx_data);
      busy_cnt <= busy_rand ? $urandom_range(1, 12) : 10;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end
  assign uart_tx_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (rx_err)  err_cnt  <= err_cnt + 1;
  end

  // Rx reference model
`ifdef UPPERCASE_HEX_EN
  localparam bit UP = 1'b1;
`else
  localparam bit UP = 1'b0;
`endif
  int          m_cnt;
  logic [31:0] m_acc;
  logic [31:0] m_word;
  bit          m_hold;

  function automatic int hex_val(input logic [7:0] ch);
    int c;
    c = int'(ch);
    if (c >= 48 && c <= 57)        return c - 48;
    if (c >= 97 && c <= 102)       return c - 87;
    if (UP && c >= 65 && c <= 70)  return c - 55;
    return -1;
  endfunction

  function automatic logic [7:0] fold(input logic [7:0] ch);
    if (UP && ch >= 8'd65 && ch <= 8'd70) return ch + 8'd32;
    return ch;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_acc = 0; m_word = 0; m_hold = 1'b0;
  endtask

  // drivers
  task automatic send_rx(input logic [7:0] c, input bit strobe, input bit ack);
    int v;
    bit e_err, e_ovr;
    @(negedge clk);
    uart_rx_data  = c;
    uart_rx_valid = strobe;
    rx_word_ack   = ack;
    #1;
    if (strobe) check("rx_fold", {24'd0, tr_rx_ascii}, {24'd0, fold(c)});
    e_err = 1'b0;
    e_ovr = 1'b0;
    if (m_hold) begin
      e_ovr = strobe;
      if (ack) m_hold = 1'b0;
    end else if (strobe) begin
      v = hex_val(c);
      if (v < 0) e_err = 1'b1;
      else begin
        m_acc = m_acc * 16 + 32'(v);
        m_cnt++;
        if (m_cnt == NIB) begin
          m_word = m_acc; m_acc = 0; m_cnt = 0; m_hold = 1'b1;
        end
      end
    end
    @(negedge clk);
    uart_rx_valid = 1'b0;
    rx_word_ack   = 1'b0;
    check("rx_err", {31'd0, rx_err}, {31'd0, e_err});
    check("rx_overrun", {31'd0, rx_overrun}, {31'd0, e_ovr});
    check("rx_valid", {31'd0, rx_word_valid}, {31'd0, m_hold});
    if (m_hold) check("rx_word", rx_word, m_word);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_rx(s[i], 1'b1, 1'b0);
  endtask

  task automatic send_tx(input logic [31:0] w, input bit poke);
    int d0, n;
    n = 0;
    while (tx_busy && n < BUDGET) begin @(negedge clk); n++; end
    check("tx_idle_wait", {31'd0, tx_busy}, 32'd0);
    @(negedge clk);
    tx_word = w;
    tx_req  = 1'b1;
    for (int i = NIB - 1; i >= 0; i--) exp_q.push_back({24'd0, hex_char(int'((w >> (4 * i)) & 32'hF))});
    d0 = done_cnt;
    @(negedge clk);
    tx_req  = 1'b0;
    tx_word = $urandom;
    check("tx_busy", {31'd0, tx_busy}, 32'd1);
    n = 0;
    while (done_cnt == d0 && n < BUDGET) begin
      @(negedge clk);
      n++;
      tx_req = poke && (n == 30);
    end
    tx_req = 1'b0;
    check("tx_timeout", {31'd0, (n < BUDGET)}, 32'd1);
    repeat (2) @(negedge clk);
    check("tx_done_cnt", done_cnt, d0 + 1);
    check("tx_nchar", obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) check("tx_char", {24'd0, obs_q.pop_front()}, exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
    check("tx_back_idle", {31'd0, tx_busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_word"}, rx_word, 32'd0);
    check({tag, "_flags"}, {26'd0, rx_word_valid, rx_err, rx_overrun, tx_done, uart_tx_start, tx_busy}, 32'd0);
    check({tag, "_txdata"}, {24'd0, uart_tx_data}, 32'd0);
    check({tag, "_trval"}, {24'd0, tr_tx_value}, 32'd0);
  endtask

  function automatic logic [7:0] rand_char();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 3) return 8'(48 + $urandom_range(0, 9));
    if (r <= 5) return 8'(97 + $urandom_range(0, 5));
    if (r <= 7) return 8'(65 + $urandom_range(0, 5));
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    int d0, e0, n;
    reset = 1'b0; uart_rx_data = 0; uart_rx_valid = 0; rx_word_ack = 0;
    tx_word = 0; tx_req = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);

    // Rx directed
    send_str("1a2b3c4d");
    check("dir_1a2b", rx_word, 32'h1A2B3C4D);
    send_rx(8'd0, 1'b0, 1'b1);
    send_str("12g45678");
    check("dir_g_novalid", {31'd0, rx_word_valid}, 32'd0);
    send_rx(8'd57, 1'b1, 1'b0);
    check("dir_12456789", rx_word, 32'h12456789);
    send_rx(8'd48, 1'b1, 1'b0);
    check("dir_ovr_word", rx_word, 32'h12456789);
    send_rx(8'd0, 1'b0, 1'b0);
    send_rx(8'd49, 1'b1, 1'b1);
    send_str("0f9e8d7c");
    check("dir_0f9e", rx_word, 32'h0F9E8D7C);
    send_rx(8'd0, 1'b0, 1'b1);

    // Tx directed, with a req poked mid-send
    send_tx(32'hDEADBEEF, 1'b1);

    // reset mid-operation
    send_str("12345");
    @(negedge clk);
    tx_word = 32'h13579BDF;
    tx_req  = 1'b1;
    @(negedge clk);
    tx_req  = 1'b0;
    n = 0;
    while (obs_q.size() < 3 && n < BUDGET) begin @(negedge clk); n++; end
    check("rst_third_char", {31'd0, (obs_q.size() >= 3)}, 32'd1);
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (200) @(negedge clk);
    check("rst_no_done", done_cnt, d0);
    check("rst_no_more_chars", obs_q.size(), 3);
    check("rst_tx_idle", {31'd0, tx_busy}, 32'd0);
    obs_q.delete();
    send_str("ffffffff");
    check("dir_ffffffff", rx_word, 32'hFFFFFFFF);
    send_rx(8'd0, 1'b0, 1'b1);

    // uppercase input
    e0 = err_cnt;
    send_str("ABCDEF01");
`ifdef UPPERCASE_HEX_EN
    check("upper_word", rx_word, 32'hABCDEF01);
    send_rx(8'd0, 1'b0, 1'b1);
`else
    @(negedge clk);
    check("upper_errs", err_cnt - e0, 6);
`endif

    // concurrent random traffic
    busy_rand = 1'b1;
    fork
      begin
        repeat (5) send_tx($urandom, 1'($urandom_range(0, 1)));
      end
      begin
        repeat (80) begin
          if (m_hold && $urandom_range(0, 2) == 0)
            send_rx(rand_char(), 1'($urandom_range(0, 1)), 1'b1);
          else
            send_rx(rand_char(), 1'b1, $urandom_range(0, 7) == 0);
        end
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
